// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose : FSM state encoding, word/lane widths and the lane-alignment
//           helper used by dmem_responder and dmem_array.
// Contents: WORD_W, BYTE_W, BE_W, CNT_W, state_t, aligned_lanes().
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BE_W   = WORD_W / BYTE_W;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Lanes a store may touch given the byte offset: offset 0 may cover the
  // whole word, offset 2 the upper half-word, odd offsets a single byte.
  function automatic logic [BE_W-1:0] aligned_lanes(input logic [1:0] off);
    logic [BE_W-1:0] m;
    case (off)
      2'd0:    m = 4'b1111;
      2'd1:    m = 4'b0010;
      2'd2:    m = 4'b1100;
      default: m = 4'b1000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with per-byte-lane write and registered read
//
// Purpose : DEPTH_WORDS x 32-bit storage, contents never reset.
// Ports   : CLK      clock (rising edge)
//           wr_en    write strobe; bytes written where wr_be[i]=1
//           wr_be    byte-lane enables, bit i -> [8i+7:8i]
//           wdata    write data
//           rd_en    load strobe; rd_data captures mem[idx] on the edge
//           idx      word index shared by read and write
//           rd_data  registered read data, holds until the next rd_en
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           CLK,
  input  logic                           wr_en,
  input  logic [BE_W-1:0]                wr_be,
  input  logic [WORD_W-1:0]              wdata,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  output logic [WORD_W-1:0]              rd_data
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[idx][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder with valid/ready handshakes
//
// Purpose : Accepts one load/store at a time, waits WAIT_CYCLES, performs the
//           array access on the edge entering RESP and holds the response
//           until RSP_READY. Out-of-range addresses fault without writing.
// Config  : define DMEM_MISALIGN_CHECK_EN to also fault misaligned requests.
// Ports   : CLK, RST (sync, active-high)
//           REQ_VALID/REQ_READY, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE
//           RSP_VALID/RSP_READY, RSP_RDATA, RSP_ERR
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [WORD_W-1:0] REQ_ADDR,
  input  logic [WORD_W-1:0] REQ_WDATA,
  input  logic [BE_W-1:0]   REQ_BE,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [WORD_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               enter_resp;
  logic               accept;

  logic               lat_we;
  logic [WORD_W-1:0]  lat_addr, lat_wdata;
  logic [BE_W-1:0]    lat_be;

  logic               cur_we;
  logic [WORD_W-1:0]  cur_addr, cur_wdata;
  logic [BE_W-1:0]    cur_be;
  logic               range_err, misalign_err, cur_err;

  logic               rsp_err_q, rsp_load_q;
  logic               arr_wr_en, arr_rd_en;
  logic [WORD_W-1:0]  arr_rdata;

  assign accept = (state == IDLE) && REQ_VALID;

  // With zero wait states RESP is entered on the accept edge itself, before
  // the latches hold the request, so the live inputs are used in IDLE.
  assign cur_we    = (state == IDLE) ? REQ_WE    : lat_we;
  assign cur_addr  = (state == IDLE) ? REQ_ADDR  : lat_addr;
  assign cur_wdata = (state == IDLE) ? REQ_WDATA : lat_wdata;
  assign cur_be    = (state == IDLE) ? REQ_BE    : lat_be;

  assign range_err = (cur_addr[WORD_W-1:AW+2] != '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_err = (cur_addr[1:0] != 2'b00) ||
                        (cur_we && ((cur_be & ~aligned_lanes(cur_addr[1:0])) != '0));
`else
  logic unused_addr_lsb;
  assign misalign_err    = 1'b0;
  assign unused_addr_lsb = ^cur_addr[1:0];
`endif

  assign cur_err = range_err || misalign_err;

  // Reset wins over the RESP-entry edge so an abandoned store never lands.
  assign arr_wr_en = enter_resp && cur_we  && !cur_err && !RST;
  assign arr_rd_en = enter_resp && !cur_we && !cur_err && !RST;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_resp) begin
        rsp_err_q  <= cur_err;
        rsp_load_q <= !cur_we;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      lat_we    <= REQ_WE;
      lat_addr  <= REQ_ADDR;
      lat_wdata <= REQ_WDATA;
      lat_be    <= REQ_BE;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .CLK    (CLK),
    .wr_en  (arr_wr_en),
    .wr_be  (cur_be),
    .wdata  (cur_wdata),
    .rd_en  (arr_rd_en),
    .idx    (cur_addr[AW+1:2]),
    .rd_data(arr_rdata)
  );

  // The array read register is not reset; gating by state keeps the
  // response outputs at zero outside RESP and for stores/faults.
  assign REQ_READY = (state == IDLE);
  assign RSP_VALID = (state == RESP);
  assign RSP_ERR   = (state == RESP) && rsp_err_q;
  assign RSP_RDATA = ((state == RESP) && rsp_load_q && !rsp_err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_WE = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic [3:0]  REQ_BE = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_WE   (REQ_WE),
    .REQ_ADDR (REQ_ADDR),
    .REQ_WDATA(REQ_WDATA),
    .REQ_BE   (REQ_BE),
    .RSP_VALID(RSP_VALID),
    .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA),
    .RSP_ERR  (RSP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl[int];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_req(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    int          idx;
    logic [31:0] w;
    e.err   = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) e.err = 1'b1;
`endif
    e.rdata = '0;
    idx     = int'(addr[9:2]);
    if (!e.err) begin
      if (we) begin
        w = mdl.exists(idx) ? mdl[idx] : 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        end
        mdl[idx] = w;
      end else begin
        e.rdata = mdl.exists(idx) ? mdl[idx] : 32'h0;
      end
    end
    return e;
  endfunction

  // One full transaction: issue, verify latency and hold behaviour with
  // RSP_READY low for 'hold' cycles, then complete and confirm IDLE.
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge CLK);
    check_val("req_ready_idle", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    REQ_BE    = be;
    RSP_READY = 1'b0;
    sb.push_back(model_req(we, addr, wdata, be));
    @(posedge CLK);
    lat = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (RSP_VALID) got = 1;
      else check_val("req_ready_busy", REQ_READY, 0);
      // Junk on the request bus while busy must be ignored.
      REQ_WE    = ~we;
      REQ_ADDR  = $urandom & 32'h0000_03FC;
      REQ_WDATA = $urandom;
      REQ_BE    = 4'hF;
    end
    if (!got) begin
      check_val("rsp_valid_timeout", RSP_VALID, 1);
      void'(sb.pop_front());
      REQ_VALID = 1'b0;
      return;
    end
    check_val("rsp_latency", lat, WAITS + 1);
    e = sb[0];
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check_val("hold_valid", RSP_VALID, 1);
      check_val("hold_rdata", RSP_RDATA, e.rdata);
      check_val("hold_err", RSP_ERR, e.err);
      check_val("hold_req_ready", REQ_READY, 0);
    end
    RSP_READY = 1'b1;
    e = sb.pop_front();
    check_val("rsp_rdata", RSP_RDATA, e.rdata);
    check_val("rsp_err", RSP_ERR, e.err);
    @(posedge CLK);
    @(negedge CLK);
    RSP_READY = 1'b0;
    check_val("idle_req_ready", REQ_READY, 1);
    check_val("idle_rsp_valid", RSP_VALID, 0);
    REQ_VALID = 1'b0;
  endtask

  // Store abandoned by reset on the edge that would have entered RESP.
  task automatic do_reset_in_wait(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_WE    = 1'b1;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    REQ_BE    = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check_val("rst_wait_busy", REQ_READY, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_val("rst_req_ready", REQ_READY, 1);
    check_val("rst_rsp_valid", RSP_VALID, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_val("rst_no_rsp", RSP_VALID, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_val("reset_req_ready", REQ_READY, 1);
    check_val("reset_rsp_valid", RSP_VALID, 0);
    check_val("reset_rsp_rdata", RSP_RDATA, 0);
    check_val("reset_rsp_err", RSP_ERR, 0);

    do_req(1'b1, 32'h0000_0000, 32'hA5A5_0F0F, 4'hF, 0);
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0);

    do_req(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1);
    do_req(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 0);
    do_req(1'b0, 32'h0000_0020, 32'h0,         4'h0, 5);

    do_req(1'b0, 32'h0000_0400, 32'h0,         4'h0, 0);
    do_req(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 0);
    do_req(1'b0, 32'h0000_0000, 32'h0,         4'h0, 0);

    do_req(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 0);
    do_reset_in_wait(32'h0000_0030, 32'hFFFF_FFFF);
    do_req(1'b0, 32'h0000_0030, 32'h0,         4'h0, 0);

    do_req(1'b0, 32'h0000_0012, 32'h0,         4'h0, 0);

    do_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0000, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0);

    for (int k = 0; k < 8; k++) begin
      do_req(1'b1, 32'h0000_0100 + 32'(4 * k), $urandom, 4'hF, 0);
    end
    for (int n = 0; n < 12; n++) begin
      a = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
